td4x_core: RTL and testbench

Parametrised next-generation TD4-class 4-bit-ISA processor core. Widths are configurable: data and immediate are DW bits, the program counter is AW bits. Instructions are fetched over a req/ack program-memory handshake instead of arriving as direct opcode/immediate inputs. Adds a fetch/execute FSM, single-step control, a HLT instruction, ADD A,B, and an output-write strobe; it sits between the program ROM/loader and the board I/O pins.

---
 rtl/td4x_core_if.sv | 13 +
 rtl/td4x_core.sv | 123 ++++++++++++
 tb/tb_td4x_core.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/td4x_core_if.sv
// rtl/td4x_core_if.sv - program-memory fetch bus between td4x_core and its ROM/loader
interface td4x_core_if #(
  parameter int DW = 4,
  parameter int AW = 4
);
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW+3:0] mem_data;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_data);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_data);
endinterface

// File: rtl/td4x_core.sv
// rtl/td4x_core.sv - parametrised TD4-class core with req/ack fetch, single-step and HLT
module td4x_core #(
  parameter int DW = 4,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  td4x_core_if.master   mem,
  input  logic [DW-1:0] io_input,
  input  logic          exec_mode,
  input  logic          step,
  output logic [DW-1:0] regA_o,
  output logic [DW-1:0] regB_o,
  output logic [DW-1:0] regOut,
  output logic          out_strobe,
  output logic [AW-1:0] pc_out,
  output logic          carry,
  output logic          halted
);

  if (AW > DW) begin : g_bad_width
    $error("td4x_core: AW must not exceed DW");
  end

  localparam logic [3:0] OP_ADDA_IM = 4'b0000, OP_ADDB_IM = 4'b1010, OP_ADD_AB  = 4'b0001,
                         OP_MOVA_IM = 4'b1100, OP_MOVB_IM = 4'b1110, OP_MOV_AB  = 4'b1000,
                         OP_MOV_BA  = 4'b0010, OP_IN_A    = 4'b0100, OP_IN_B    = 4'b0110,
                         OP_OUT_B   = 4'b1001, OP_OUT_IM  = 4'b1101, OP_JMP     = 4'b1111,
                         OP_JNC     = 4'b0111, OP_HLT     = 4'b1011;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

  state_t        state;
  logic [DW+3:0] ir;
  logic [DW-1:0] reg_a, reg_b, reg_out;
  logic [AW-1:0] pc;
  logic          carry_q, req_q, strobe_q, halted_q;

  logic [3:0]    op;
  logic [DW-1:0] imm, add_l, add_r;
  logic [DW:0]   sum;
  logic          jump;

  // One shared adder serves all three ADD forms; carry-out is sum[DW].
  always_comb begin
    op    = ir[DW+3:DW];
    imm   = ir[DW-1:0];
    add_l = (op == OP_ADDB_IM) ? reg_b : reg_a;
    add_r = (op == OP_ADDA_IM || op == OP_ADDB_IM) ? imm : reg_b;
    sum   = {1'b0, add_l} + {1'b0, add_r};
    jump  = (op == OP_JMP) || (op == OP_JNC && !carry_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ir       <= '0;
      reg_a    <= '0;
      reg_b    <= '0;
      reg_out  <= '0;
      pc       <= '0;
      carry_q  <= 1'b0;
      req_q    <= 1'b0;
      strobe_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (exec_mode || step) begin
            state <= S_FETCH;
            req_q <= 1'b1;
          end
        end
        S_FETCH: begin
          if (mem.mem_ack) begin
            ir    <= mem.mem_data;
            req_q <= 1'b0;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          carry_q <= 1'b0;
          case (op)
            OP_ADDA_IM, OP_ADD_AB: begin reg_a <= sum[DW-1:0]; carry_q <= sum[DW]; end
            OP_ADDB_IM:            begin reg_b <= sum[DW-1:0]; carry_q <= sum[DW]; end
            OP_MOVA_IM:            reg_a <= imm;
            OP_MOVB_IM:            reg_b <= imm;
            OP_MOV_AB:             reg_a <= reg_b;
            OP_MOV_BA:             reg_b <= reg_a;
            OP_IN_A:               reg_a <= io_input;
            OP_IN_B:               reg_b <= io_input;
            OP_OUT_B:              begin reg_out <= reg_b; strobe_q <= 1'b1; end
            OP_OUT_IM:             begin reg_out <= imm;   strobe_q <= 1'b1; end
            default: ;
          endcase
          pc <= jump ? imm[AW-1:0] : pc + 1'b1;
          if (op == OP_HLT) begin
            state    <= S_HALT;
            halted_q <= 1'b1;
          end else if (exec_mode) begin
            state <= S_FETCH;
            req_q <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = pc;
  assign regA_o       = reg_a;
  assign regB_o       = reg_b;
  assign regOut       = reg_out;
  assign out_strobe   = strobe_q;
  assign pc_out       = pc;
  assign carry        = carry_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_td4x_core.sv
// tb/tb_td4x_core.sv - directed table and sequence checks for td4x_core
module tb_td4x_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DW=4/AW=4 core
  td4x_core_if #(.DW(4), .AW(4)) bus ();
  logic [3:0] io_in = '0, a1, b1, o1, pc1;
  logic       exec_mode = 1'b0, step = 1'b0, stb1, c1, h1;
  logic [7:0] rom [16];
  int         wait_n = 0, wcnt = 0;
  logic       ack_en = 1'b1;

  assign bus.mem_ack  = bus.mem_req && ack_en && (wcnt >= wait_n);
  assign bus.mem_data = rom[bus.mem_addr];
  always @(posedge clk) wcnt <= (bus.mem_req && !bus.mem_ack) ? wcnt + 1 : 0;

  td4x_core #(.DW(4), .AW(4)) dut (
    .clk(clk), .rst_n(rst_n), .mem(bus), .io_input(io_in), .exec_mode(exec_mode), .step(step),
    .regA_o(a1), .regB_o(b1), .regOut(o1), .out_strobe(stb1), .pc_out(pc1), .carry(c1), .halted(h1)
  );

  // DW=8/AW=6 core, zero-wait memory
  td4x_core_if #(.DW(8), .AW(6)) bus2 ();
  logic [7:0]  a2, b2, o2;
  logic [5:0]  pc2;
  logic        step2 = 1'b0, stb2, c2, h2;
  logic [11:0] rom2 [64];

  assign bus2.mem_ack  = bus2.mem_req;
  assign bus2.mem_data = rom2[bus2.mem_addr];

  td4x_core #(.DW(8), .AW(6)) dut2 (
    .clk(clk), .rst_n(rst_n), .mem(bus2), .io_input(8'h00), .exec_mode(1'b0), .step(step2),
    .regA_o(a2), .regB_o(b2), .regOut(o2), .out_strobe(stb2), .pc_out(pc2), .carry(c2), .halted(h2)
  );

  // Monitor on the DW=4 core: fetch-address stability, fetch period, strobe count
  logic       mon_clr = 1'b0, req_prev = 1'b0;
  logic [3:0] addr_prev = '0;
  int addr_bad = 0, period_bad = 0, rises = 0, since = 0, stb_cnt = 0, exp_period = 2;
  always @(negedge clk) begin
    req_prev  <= bus.mem_req;
    addr_prev <= bus.mem_addr;
    if (mon_clr) begin
      addr_bad <= 0; period_bad <= 0; rises <= 0; since <= 0; stb_cnt <= 0;
    end else begin
      if (bus.mem_req && req_prev && bus.mem_addr != addr_prev) addr_bad <= addr_bad + 1;
      if (bus.mem_req && !req_prev) begin
        rises <= rises + 1;
        if (rises > 0 && since != exp_period) period_bad <= period_bad + 1;
        since <= 1;
      end else begin
        since <= since + 1;
      end
      if (stb1) stb_cnt <= stb_cnt + 1;
    end
  end

  int total = 0, bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_step(input bit second);
    @(negedge clk);
    if (second) step2 = 1'b1; else step = 1'b1;
    @(negedge clk);
    step = 1'b0; step2 = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (!h1 && n < budget) begin @(negedge clk); n++; end
    check("halt_reached", h1, 1'b1);
  endtask

  // Runs MOV A,9; ADD A,8; JNC 0; OUT Im 5; HLT free-running with the given wait states
  task automatic run_carry_prog(input int ws, input int per);
    rom[0] = 8'hC9; rom[1] = 8'h08; rom[2] = 8'h70; rom[3] = 8'hD5; rom[4] = 8'hB0;
    wait_n = ws; exp_period = per; exec_mode = 1'b1;
    @(negedge clk); mon_clr = 1'b1; rst_n = 1'b0;
    @(negedge clk); mon_clr = 1'b0; rst_n = 1'b1;
    wait_halt(200);
    check($sformatf("prog_w%0d_a", ws), a1, 4'h1);
    check($sformatf("prog_w%0d_out", ws), o1, 4'h5);
    check($sformatf("prog_w%0d_carry", ws), c1, 1'b0);
    check($sformatf("prog_w%0d_pc", ws), pc1, 4'h5);
    check($sformatf("prog_w%0d_strobes", ws), stb_cnt, 1);
    check($sformatf("prog_w%0d_fetches", ws), rises, 5);
    check($sformatf("prog_w%0d_period", ws), period_bad, 0);
    check($sformatf("prog_w%0d_addr_stable", ws), addr_bad, 0);
    exec_mode = 1'b0;
  endtask

  typedef struct {
    logic [7:0] instr;
    logic [3:0] io;
    logic [3:0] a, b, o;
    logic       c;
    logic [3:0] pc;
    int         stb;
  } vec_t;

  vec_t vec [18];

  initial begin
    int n;
    logic [3:0] cur_pc;
    vec[0]  = '{8'hC9, 4'h0, 4'h9, 4'h0, 4'h0, 1'b0, 4'd1,  0};  // MOV A,9
    vec[1]  = '{8'h08, 4'h0, 4'h1, 4'h0, 4'h0, 1'b1, 4'd2,  0};  // ADD A,8 -> carry
    vec[2]  = '{8'h70, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0, 4'd3,  0};  // JNC 0 not taken
    vec[3]  = '{8'hD5, 4'h0, 4'h1, 4'h0, 4'h5, 1'b0, 4'd4,  1};  // OUT Im 5
    vec[4]  = '{8'hE3, 4'h0, 4'h1, 4'h3, 4'h5, 1'b0, 4'd5,  0};  // MOV B,3
    vec[5]  = '{8'h13, 4'h0, 4'h4, 4'h3, 4'h5, 1'b0, 4'd6,  0};  // ADD A,B
    vec[6]  = '{8'hAF, 4'h0, 4'h4, 4'h2, 4'h5, 1'b1, 4'd7,  0};  // ADD B,F wraps
    vec[7]  = '{8'h80, 4'h0, 4'h2, 4'h2, 4'h5, 1'b0, 4'd8,  0};  // MOV A,B
    vec[8]  = '{8'h40, 4'hA, 4'hA, 4'h2, 4'h5, 1'b0, 4'd9,  0};  // IN A
    vec[9]  = '{8'h20, 4'h0, 4'hA, 4'hA, 4'h5, 1'b0, 4'd10, 0};  // MOV B,A
    vec[10] = '{8'h60, 4'h6, 4'hA, 4'h6, 4'h5, 1'b0, 4'd11, 0};  // IN B
    vec[11] = '{8'h90, 4'h0, 4'hA, 4'h6, 4'h6, 1'b0, 4'd12, 1};  // OUT B
    vec[12] = '{8'h30, 4'h0, 4'hA, 4'h6, 4'h6, 1'b0, 4'd13, 0};  // NOP
    vec[13] = '{8'h07, 4'h0, 4'h1, 4'h6, 4'h6, 1'b1, 4'd14, 0};  // ADD A,7 -> carry
    vec[14] = '{8'h50, 4'h0, 4'h1, 4'h6, 4'h6, 1'b0, 4'd15, 0};  // NOP clears carry
    vec[15] = '{8'h74, 4'h0, 4'h1, 4'h6, 4'h6, 1'b0, 4'd4,  0};  // JNC 4 taken
    vec[16] = '{8'hD6, 4'h0, 4'h1, 4'h6, 4'h6, 1'b0, 4'd5,  1};  // OUT Im 6, same value
    vec[17] = '{8'hF1, 4'h0, 4'h1, 4'h6, 4'h6, 1'b0, 4'd1,  0};  // JMP 1

    for (int i = 0; i < 16; i++) rom[i] = 8'h30;
    for (int i = 0; i < 64; i++) rom2[i] = 12'h000;

    // Reset state
    #12;
    check("rst_req", bus.mem_req, 1'b0);
    check("rst_pc", pc1, 4'h0);
    check("rst_a", a1, 4'h0);
    check("rst_strobe", stb1, 1'b0);
    check("rst_halted", h1, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    // DW=8/AW=6 arithmetic and jump truncation
    rom2[0] = 12'hE01; rom2[1] = 12'hAFF; rom2[2] = 12'hFC5; rom2[5] = 12'hB00;
    pulse_step(1'b1);
    pulse_step(1'b1);
    check("w8_b_wrap", b2, 8'h00);
    check("w8_carry", c2, 1'b1);
    check("w8_pc", pc2, 6'd2);
    pulse_step(1'b1);
    check("w8_jmp_pc", pc2, 6'h05);
    check("w8_jmp_carry", c2, 1'b0);
    pulse_step(1'b1);
    check("w8_halted", h2, 1'b1);
    check("w8_halt_pc", pc2, 6'd6);

    // Single-step table on the DW=4 core
    cur_pc = 4'd0;
    for (int i = 0; i < 18; i++) begin
      int s0;
      rom[cur_pc] = vec[i].instr;
      io_in = vec[i].io;
      s0 = stb_cnt;
      pulse_step(1'b0);
      check($sformatf("v%0d_a", i), a1, vec[i].a);
      check($sformatf("v%0d_b", i), b1, vec[i].b);
      check($sformatf("v%0d_out", i), o1, vec[i].o);
      check($sformatf("v%0d_carry", i), c1, vec[i].c);
      check($sformatf("v%0d_pc", i), pc1, vec[i].pc);
      check($sformatf("v%0d_strobe", i), stb_cnt - s0, vec[i].stb);
      cur_pc = vec[i].pc;
    end

    // Second step pulse during a waited fetch is dropped
    wait_n = 3;
    rom[1] = 8'h08;
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
    repeat (10) @(negedge clk);
    check("drop_pc", pc1, 4'd2);
    check("drop_a", a1, 4'h9);
    check("drop_idle_req", bus.mem_req, 1'b0);

    // Reset while a fetch is outstanding
    ack_en = 1'b0; exec_mode = 1'b1;
    repeat (3) @(negedge clk);
    check("midfetch_req", bus.mem_req, 1'b1);
    check("midfetch_addr", bus.mem_addr, 4'd2);
    rst_n = 1'b0;
    #1;
    check("midfetch_rst_req", bus.mem_req, 1'b0);
    check("midfetch_rst_pc", pc1, 4'h0);
    check("midfetch_rst_a", a1, 4'h0);
    check("midfetch_rst_b", b1, 4'h0);
    check("midfetch_rst_out", o1, 4'h0);
    @(negedge clk); ack_en = 1'b1; rst_n = 1'b1;
    @(negedge clk);
    check("refetch_req", bus.mem_req, 1'b1);
    check("refetch_addr", bus.mem_addr, 4'd0);
    exec_mode = 1'b0;

    // Same program, zero-wait and 3-wait
    run_carry_prog(0, 2);
    run_carry_prog(3, 5);

    // PC wrap over 16 NOPs
    for (int i = 0; i < 16; i++) rom[i] = 8'h30;
    wait_n = 0; exec_mode = 1'b1;
    do_reset();
    n = 0;
    while (pc1 != 4'd15 && n < 100) begin @(negedge clk); n++; end
    check("wrap_reach15", pc1, 4'd15);
    n = 0;
    while (pc1 == 4'd15 && n < 10) begin @(negedge clk); n++; end
    check("wrap_to0", pc1, 4'd0);
    exec_mode = 1'b0;

    // HLT at address 2, then stimulus must not move the core
    rom[2] = 8'hB0;
    exec_mode = 1'b1;
    do_reset();
    wait_halt(50);
    check("hlt_pc", pc1, 4'd3);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); step = i[0]; exec_mode = ~i[0];
    end
    step = 1'b0; exec_mode = 1'b0;
    repeat (3) @(negedge clk);
    check("hlt_pc_hold", pc1, 4'd3);
    check("hlt_req_low", bus.mem_req, 1'b0);
    check("hlt_still", h1, 1'b1);
    rst_n = 1'b0;
    #1;
    check("hlt_reset_clears", h1, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
